// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core fetch path: reset PC, sequential
// step size and the fetch controller state encoding.
package npc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int unsigned PC_STEP = 4;

  // Fetch controller states.
  typedef logic [2:0] state_t;
  localparam state_t ST_REQ   = 3'd0;
  localparam state_t ST_WAIT  = 3'd1;
  localparam state_t ST_ISSUE = 3'd2;
  localparam state_t ST_EXEC  = 3'd3;
  localparam state_t ST_HALT  = 3'd4;

endpackage

// File: rtl/ifu_pc_ctrl_if.sv
// Bundle of the fetch controller's memory, decode and commit signals.
// master: the PC/fetch controller. slave: memory, decode and execute side.
interface ifu_pc_ctrl_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            commit_valid;
  logic            pc_a_sel;
  logic            pc_b_sel;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic            halt;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, pc, halt,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input  commit_valid, pc_a_sel, pc_b_sel, imm, rs1
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, pc, halt,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output commit_valid, pc_a_sel, pc_b_sel, imm, rs1
  );

endinterface

// File: rtl/pc_next_adder.sv
// Next-PC computation: (pc or rs1) + (4 or imm), JALR bit-0 clear and
// misalignment flag. Purely combinational so a pipelined fetch can reuse it.
module pc_next_adder
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            pc_a_sel,
  input  logic            pc_b_sel,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;

  // Select operands, add with wraparound, clear bit 0 for JALR, flag misalignment.
  always_comb begin
    base       = pc_b_sel ? rs1 : pc;
    offset     = pc_a_sel ? imm : XLEN'(PC_STEP);
    next_pc    = base + offset;
    if (pc_b_sel) begin
      next_pc[0] = 1'b0;
    end
    misaligned = |next_pc[1:0];
  end

endmodule

// File: rtl/ifu_pc_ctrl.sv
// Program-counter and instruction-fetch controller. Holds the architectural
// PC, runs one fetch at a time, buffers the instruction for decode and
// updates the PC on commit. A misaligned target halts fetch until reset.
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   ST_REQ   | fetch request presented at pc, waiting for ready
//   ST_WAIT  | request accepted, waiting for instruction data
//   ST_ISSUE | instruction buffered and offered to decode
//   ST_EXEC  | decode took it, waiting for commit from execute
//   ST_HALT  | misaligned target seen; no further fetches
module ifu_pc_ctrl
  import npc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input logic            clk,
  input logic            rst_n,
  ifu_pc_ctrl_if.master  bus
);

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic            halt_q;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;
  logic            commit_take;

  pc_next_adder #(
    .XLEN (XLEN)
  ) u_pc_next_adder (
    .pc         (pc_q),
    .rs1        (bus.rs1),
    .imm        (bus.imm),
    .pc_a_sel   (bus.pc_a_sel),
    .pc_b_sel   (bus.pc_b_sel),
    .next_pc    (next_pc),
    .misaligned (next_misaligned)
  );

  // Commit is only meaningful while waiting for it in ST_EXEC.
  assign commit_take = (state_q == ST_EXEC) && bus.commit_valid;

  // Fetch state sequencing; each state only looks at its own handshake input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
    end else begin
      case (state_q)
        ST_REQ:   if (bus.imem_req_ready)  state_q <= ST_WAIT;
        ST_WAIT:  if (bus.imem_resp_valid) state_q <= ST_ISSUE;
        ST_ISSUE: if (bus.inst_ready)      state_q <= ST_EXEC;
        ST_EXEC:  if (bus.commit_valid)    state_q <= next_misaligned ? ST_HALT : ST_REQ;
        ST_HALT:  state_q <= ST_HALT;
        default:  state_q <= ST_HALT;
      endcase
    end
  end

  // PC moves only on an aligned commit; a misaligned target leaves it in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (commit_take && !next_misaligned) begin
      pc_q <= next_pc;
    end
  end

  // Instruction buffer captures the response only while a fetch is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q <= 32'h0;
    end else if ((state_q == ST_WAIT) && bus.imem_resp_valid) begin
      inst_q <= bus.imem_resp_data;
    end
  end

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else if (commit_take && next_misaligned) begin
      halt_q <= 1'b1;
    end
  end

  // Handshake valids decode registered state only.
  assign bus.imem_req_valid = (state_q == ST_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == ST_ISSUE);
  assign bus.inst           = inst_q;
  assign bus.pc             = pc_q;
  assign bus.halt           = halt_q;

endmodule

// File: tb/tb_ifu_pc_ctrl.sv
// Directed bench for ifu_pc_ctrl with a transaction-level reference model
// checked every cycle plus literal expectations at key points.
module tb_ifu_pc_ctrl;
  import npc_pkg::*;

  localparam int          XLEN = 32;
  localparam logic [31:0] RPC  = 32'h8000_0000;

  // Fetch lifecycle phases of the reference model.
  localparam int P_REQ = 0, P_WAIT = 1, P_ISSUE = 2, P_EXEC = 3, P_HALT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ifu_pc_ctrl_if #(.XLEN(XLEN)) bus ();

  ifu_pc_ctrl #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          m_phase = P_REQ;
  logic [31:0] m_pc    = RPC;
  logic [31:0] m_inst  = 32'h0;
  logic        m_halt  = 1'b0;

  logic [31:0] fq_addr[$];
  int          fq_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_resp_data = mem_word(bus.imem_req_addr);

  // Target arithmetic done in wide integers and reduced modulo 2^32.
  function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [31:0] rs1,
                                               input logic [31:0] imm, input logic a, input logic b);
    longint unsigned base, off, s;
    base = b ? longint'(rs1) : longint'(pc);
    off  = a ? longint'(imm) : 64'd4;
    s    = (base + off) % 64'h1_0000_0000;
    if (b) s = s - (s % 2);
    return s[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    m_phase = P_REQ;
    m_pc    = RPC;
    m_inst  = 32'h0;
    m_halt  = 1'b0;
  end

  // Model advance at each edge, then compare DUT outputs shortly after.
  always @(posedge clk) begin
    logic [31:0] tgt;
    cyc++;
    if (rst_n) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        fq_addr.push_back(bus.imem_req_addr);
        fq_cyc.push_back(cyc);
      end
      case (m_phase)
        P_REQ:   if (bus.imem_req_ready) m_phase = P_WAIT;
        P_WAIT:  if (bus.imem_resp_valid) begin
                   m_inst  = mem_word(m_pc);
                   m_phase = P_ISSUE;
                 end
        P_ISSUE: if (bus.inst_ready) m_phase = P_EXEC;
        P_EXEC:  if (bus.commit_valid) begin
                   tgt = model_target(m_pc, bus.rs1, bus.imm, bus.pc_a_sel, bus.pc_b_sel);
                   if (tgt % 4 == 0) begin
                     m_pc    = tgt;
                     m_phase = P_REQ;
                   end else begin
                     m_halt  = 1'b1;
                     m_phase = P_HALT;
                   end
                 end
        default: ;
      endcase
      #1;
      if (rst_n) begin
        chk("cyc_req_valid",  {31'b0, bus.imem_req_valid}, {31'b0, m_phase == P_REQ});
        chk("cyc_req_addr",   bus.imem_req_addr, m_pc);
        chk("cyc_inst_valid", {31'b0, bus.inst_valid}, {31'b0, m_phase == P_ISSUE});
        chk("cyc_inst",       bus.inst, m_inst);
        chk("cyc_pc",         bus.pc, m_pc);
        chk("cyc_halt",       {31'b0, bus.halt}, {31'b0, m_halt});
      end
    end
  end

  task automatic set_in(input logic rq, input logic rv, input logic ir, input logic cv);
    bus.imem_req_ready  = rq;
    bus.imem_resp_valid = rv;
    bus.inst_ready      = ir;
    bus.commit_valid    = cv;
  endtask

  task automatic wait_phase(input int p, input string name);
    for (int i = 0; i < 20 && m_phase != p; i++) @(negedge clk);
    chk(name, {31'b0, m_phase == p}, 32'd1);
  endtask

  task automatic do_commit(input logic a, input logic b, input logic [31:0] imm_v, input logic [31:0] rs1_v);
    bus.pc_a_sel     = a;
    bus.pc_b_sel     = b;
    bus.imm          = imm_v;
    bus.rs1          = rs1_v;
    bus.commit_valid = 1'b1;
    @(negedge clk);
    bus.commit_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    bus.pc_a_sel = 1'b0;
    bus.pc_b_sel = 1'b0;
    bus.imm      = 32'h0;
    bus.rs1      = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_pc",         bus.pc, RPC);
    chk("rst_inst",       bus.inst, 32'h0);
    chk("rst_halt",       {31'b0, bus.halt}, 32'd0);
    chk("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("req_valid_after_reset", {31'b0, bus.imem_req_valid}, 32'd1);

    // Sequential fetch with everything ready and commit tied high.
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (16) @(negedge clk);
    chk("seq_fetch_count", fq_addr.size(), 32'd4);
    if (fq_addr.size() >= 4) begin
      chk("seq_addr0", fq_addr[0], 32'h8000_0000);
      chk("seq_addr1", fq_addr[1], 32'h8000_0004);
      chk("seq_addr2", fq_addr[2], 32'h8000_0008);
      chk("seq_addr3", fq_addr[3], 32'h8000_000C);
      chk("seq_gap01", fq_cyc[1] - fq_cyc[0], 32'd4);
      chk("seq_gap12", fq_cyc[2] - fq_cyc[1], 32'd4);
      chk("seq_gap23", fq_cyc[3] - fq_cyc[2], 32'd4);
    end
    chk("seq_pc", bus.pc, 32'h8000_0010);

    // Branch taken backwards.
    bus.commit_valid = 1'b0;
    wait_phase(P_EXEC, "wait_exec_br");
    chk("br_pc_before", bus.pc, 32'h8000_0010);
    do_commit(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    chk("br_pc", bus.pc, 32'h8000_0000);

    // JALR, target already even.
    wait_phase(P_EXEC, "wait_exec_jalr");
    do_commit(1'b1, 1'b1, 32'h3, 32'h8000_0101);
    chk("jalr_pc", bus.pc, 32'h8000_0104);

    // JALR with wraparound past 2^32.
    wait_phase(P_EXEC, "wait_exec_wrap");
    do_commit(1'b1, 1'b1, 32'h8, 32'hFFFF_FFFC);
    chk("wrap_pc", bus.pc, 32'h0000_0004);

    // JALR whose odd target has bit 0 cleared; request then back-pressured.
    wait_phase(P_EXEC, "wait_exec_bit0");
    bus.imem_req_ready = 1'b0;
    do_commit(1'b1, 1'b1, 32'h0, 32'h8000_0201);
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
      chk("bp_req_addr", bus.imem_req_addr, 32'h8000_0200);
      @(negedge clk);
    end

    // Decode stall with a spurious commit during ISSUE.
    set_in(1'b1, 1'b1, 1'b0, 1'b1);
    wait_phase(P_ISSUE, "wait_issue");
    for (int i = 0; i < 5; i++) begin
      chk("stall_inst_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("stall_inst", bus.inst, 32'h9357_99DF);
      chk("stall_pc", bus.pc, 32'h8000_0200);
      @(negedge clk);
    end
    bus.commit_valid = 1'b0;
    bus.inst_ready   = 1'b1;
    wait_phase(P_EXEC, "wait_exec_after_stall");
    do_commit(1'b0, 1'b0, 32'h0, 32'h0);
    chk("seq_after_stall_pc", bus.pc, 32'h8000_0204);

    // Asynchronous reset between edges while waiting for a response.
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    wait_phase(P_WAIT, "wait_resp");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", bus.pc, RPC);
    chk("arst_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("arst_inst", bus.inst, 32'h0);
    set_in(1'b0, 1'b1, 1'b1, 1'b0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("late_resp_inst", bus.inst, 32'h0);
    chk("late_resp_inst_valid", {31'b0, bus.inst_valid}, 32'd0);

    // Misaligned branch target halts fetch.
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    wait_phase(P_EXEC, "wait_exec_mis");
    chk("mis_pc_before", bus.pc, RPC);
    do_commit(1'b1, 1'b0, 32'h2, 32'h0);
    chk("mis_halt", {31'b0, bus.halt}, 32'd1);
    chk("mis_pc", bus.pc, RPC);
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    n_req = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.imem_req_valid) n_req++;
    end
    chk("halt_no_req", n_req, 32'd0);
    chk("halt_sticky", {31'b0, bus.halt}, 32'd1);
    chk("halt_pc", bus.pc, RPC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_pc_ctrl.md
# ifu_pc_ctrl

Program-counter and instruction-fetch controller for the NPC core; sits directly downstream of the branch-condition unit and consumes its `pc_a_sel` and `pc_b_sel` outputs. It holds the architectural PC, issues one fetch at a time to instruction memory over a valid/ready handshake, and presents the returned instruction to decode. On the commit pulse from execute it computes the next PC as (pc or rs1) + (4 or imm) and starts the next fetch. Misaligned targets halt fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: PC value loaded on reset.
- `XLEN`, default 32: data and address width.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  imem accepts the request.
- `imem_req_addr`  out  XLEN  fetch address; equals `pc`.
- `imem_resp_valid`  in  1  instruction data valid.
- `imem_resp_data`  in  32  instruction word.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts the instruction.
- `inst`  out  32  buffered instruction.
- `pc`  out  XLEN  PC of the current instruction.
- `commit_valid`  in  1  execute finished the current instruction; next-PC inputs valid.
- `pc_a_sel`  in  1  0: add 4; 1: add imm.
- `pc_b_sel`  in  1  0: base pc; 1: base rs1 (JALR).
- `imm`  in  XLEN  immediate offset.
- `rs1`  in  XLEN  register source 1.
- `halt`  out  1  fetch halted on a misaligned target; sticky until reset.

## Operation
- States: REQ, WAIT, ISSUE, EXEC, HALT.
- REQ: `imem_req_valid`=1. On `imem_req_ready`, go to WAIT.
- WAIT: on `imem_resp_valid`, latch `imem_resp_data` into `inst` and go to ISSUE.
- ISSUE: `inst_valid`=1. On `inst_ready`, go to EXEC.
- EXEC: wait for `commit_valid`. When it arrives, compute `next = (pc_b_sel ? rs1 : pc) + (pc_a_sel ? imm : 4)`, modulo 2^XLEN with wraparound and no carry out.
  - If `pc_b_sel`=1, clear `next[0]` before the alignment check.
  - If `next[1:0]`==0: load `pc`←next and go to REQ.
  - Otherwise: `pc` is unchanged, set `halt`, go to HALT.
- HALT: absorbing. No requests are issued and all inputs are ignored.
- Ignored inputs:
  - `commit_valid` outside EXEC.
  - `imem_resp_valid` outside WAIT.
  - `imem_req_ready` outside REQ.
- Only one fetch is outstanding at any time, so there are no same-cycle request and response conflicts.

## Timing
- Reset values: state=REQ, `pc`=RESET_PC, `inst`=0, `halt`=0, `inst_valid`=0. `imem_req_valid`=1 in the first cycle after `rst_n` deasserts.
- `imem_req_valid` and `inst_valid` are decoded from registered state only; no combinational path from inputs.
- `imem_req_addr` is stable from request assertion until the handshake completes.
- Minimum loop with zero-wait memory and an immediate decode handshake is 4 cycles per instruction: REQ, WAIT, ISSUE, EXEC.
- The PC update is visible on `pc` the cycle after `commit_valid`.
- Reset assertion mid-operation: returns to REQ with `pc`=RESET_PC immediately. Any in-flight response is discarded because the state is no longer WAIT.

## Structure
- Shared package `npc_pkg`:
  - state enum encoding.
  - `RESET_PC` default.
  - `PC_STEP`=4 constant.
- Sub-module `pc_next_adder`: purely combinational. Performs base/offset muxing, JALR bit-0 clear and the misalignment flag. It is reusable by a later pipelined fetch.

## Test plan
- Reset and sequential fetch: deassert `rst_n`; ready, resp and inst_ready all tied to 1; commit with sel=00. Expect fetch addresses 0x8000_0000, 0x8000_0004, 0x8000_0008, one every 4 cycles.
- Branch taken: `pc`=0x8000_0010, `pc_a_sel`=1, `imm`=0xFFFF_FFF0. Expect next `pc`=0x8000_0000.
- JALR: `pc_a_sel`=1, `pc_b_sel`=1, `rs1`=0x8000_0101, `imm`=0x3. Expect `pc`=0x8000_0104; bit 0 is cleared and the target is aligned.
- Misaligned target: sel=01, `pc`=0x8000_0000, `imm`=0x2. Expect `halt`=1 next cycle, `pc` held at 0x8000_0000, and no further `imem_req_valid`.
- Back-pressure:
  - `imem_req_ready` low for 3 cycles: `imem_req_addr` stays stable.
  - `inst_ready` low for 5 cycles: `inst` and `inst_valid` stay stable.
  - A spurious `commit_valid` while in ISSUE is ignored.
- Async reset mid-WAIT: pulse `rst_n` low between clock edges. Expect `pc`=0x8000_0000 immediately and a late `imem_resp_valid` to be ignored.
